// File: rtl/rc4_ksa_ctrl.sv
// RC4 key-schedule controller: identity-fill the S-RAM, then run the KSA swap loop (RC4_KSA_PERF_EN adds a busy-cycle counter).
// Latency: done pulses DEPTH*(5+2*READ_LAT) cycles after the edge that samples start.
// Backpressure: none; start is a request that is ignored unless idle, and the RAM must honour READ_LAT.
module rc4_ksa_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3,
    parameter int READ_LAT  = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    input  logic [ADDR_W-1:0]      q,
    output logic                   busy,
    output logic                   done,
    output logic                   wren,
    output logic [ADDR_W-1:0]      address,
    output logic [ADDR_W-1:0]      data
`ifdef RC4_KSA_PERF_EN
    ,
    output logic [31:0]            cycles
`endif
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_INIT    = 4'd1;
    localparam logic [3:0] S_RD_SI   = 4'd2;
    localparam logic [3:0] S_WAIT_SI = 4'd3;
    localparam logic [3:0] S_RD_SJ   = 4'd4;
    localparam logic [3:0] S_WAIT_SJ = 4'd5;
    localparam logic [3:0] S_WR_SI   = 4'd6;
    localparam logic [3:0] S_WR_SJ   = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [ADDR_W-1:0] I_LAST = '1;
    localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);
    localparam logic [1:0]        W_LAST = 2'(READ_LAT - 1);

    logic [3:0]             state;
    logic [ADDR_W-1:0]      i;
    logic [ADDR_W-1:0]      j;
    logic [ADDR_W-1:0]      si;
    logic [ADDR_W-1:0]      jn;
    logic [ADDR_W-1:0]      key_term;
    logic [KW-1:0]          kidx;
    logic [1:0]             wcnt;
    logic [KEY_BYTES*8-1:0] key_r;
    logic [7:0]             key_byte;

    // Key byte 0 sits in the most significant byte of the latched key.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx == KW'(b)) begin
                key_byte = key_r[(KEY_BYTES-1-b)*8 +: 8];
            end
        end
    end

    assign key_term = ADDR_W'(key_byte);
    assign jn       = j + q + key_term;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wren    <= 1'b0;
            address <= '0;
            data    <= '0;
            i       <= '0;
            j       <= '0;
            si      <= '0;
            kidx    <= '0;
            wcnt    <= '0;
            key_r   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_r   <= secret_key;
                        i       <= '0;
                        j       <= '0;
                        kidx    <= '0;
                        busy    <= 1'b1;
                        wren    <= 1'b1;
                        address <= '0;
                        data    <= '0;
                        state   <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (i == I_LAST) begin
                        i       <= '0;
                        wren    <= 1'b0;
                        address <= '0;
                        state   <= S_RD_SI;
                    end else begin
                        i       <= i + ADDR_W'(1);
                        address <= i + ADDR_W'(1);
                        data    <= i + ADDR_W'(1);
                    end
                end
                S_RD_SI: begin
                    wcnt  <= '0;
                    state <= S_WAIT_SI;
                end
                S_WAIT_SI: begin
                    if (wcnt == W_LAST) begin
                        si      <= q;
                        j       <= jn;
                        address <= jn;
                        state   <= S_RD_SJ;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                S_RD_SJ: begin
                    wcnt  <= '0;
                    state <= S_WAIT_SJ;
                end
                S_WAIT_SJ: begin
                    if (wcnt == W_LAST) begin
                        address <= i;
                        data    <= q;
                        wren    <= 1'b1;
                        state   <= S_WR_SI;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                S_WR_SI: begin
                    address <= j;
                    data    <= si;
                    state   <= S_WR_SJ;
                end
                S_WR_SJ: begin
                    kidx <= (kidx == K_LAST) ? '0 : kidx + KW'(1);
                    wren <= 1'b0;
                    if (i == I_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        i       <= i + ADDR_W'(1);
                        address <= i + ADDR_W'(1);
                        state   <= S_RD_SI;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    wren  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RC4_KSA_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycles <= '0;
        end else if (state == S_IDLE && start) begin
            cycles <= '0;
        end else if (busy && cycles != 32'hFFFF_FFFF) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule
